// File: rtl/dac_board_3_pkg.sv
// dac_board_3_pkg: shared RX/byte-phase types and default UART timing for the DAC board 3 audio path
package dac_board_3_pkg;
  localparam int DEF_CLK_FREQ = 12_000_000;
  localparam int DEF_BAUD = 230_400;
  localparam int BIT_CYCLES = DEF_CLK_FREQ / DEF_BAUD;
  localparam int HALF_BIT = BIT_CYCLES / 2;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
  typedef enum logic {LOW, HIGH} phase_t;
endpackage

// File: rtl/dac_board_3_uart_rx.sv
// uart_rx_8n1: synchronized 8N1 receiver; pulses data_valid on a good stop bit, frame_err on a bad one
module uart_rx_8n1
  import dac_board_3_pkg::*;
#(
  parameter int BIT_CYC = BIT_CYCLES
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data,
  output logic       data_valid,
  output logic       frame_err,
  output logic       busy
);
  localparam int HALF = BIT_CYC / 2;
  localparam int CW = $clog2(BIT_CYC);
  rx_state_t state, next;
  logic [2:0] sync;
  logic [CW-1:0] cnt;
  logic [2:0] nbit;
  logic bad, line, tick;
  // sync[1:0] is the two-flop synchronizer; sync[2] only remembers the previous level for edge detection
  assign line = sync[1];
  assign tick = cnt == '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= next;
  always_comb begin
    next = state;
    case (state)
      IDLE:    if (sync[2] && !line) next = START;
      START:   if (tick) next = line ? IDLE : DATA;
      DATA:    if (tick && nbit == 3'd7) next = STOP;
      STOP:    if (tick && line) next = IDLE;
      default: next = IDLE;
    endcase
  end
  always_comb begin
    data_valid = state == STOP && tick && !bad && line;
    frame_err = state == STOP && tick && !bad && !line;
    busy = state != IDLE;
  end
  // after a bad stop bit the counter parks at zero and bad holds off further pulses until the line idles
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync <= 3'b111;
      cnt <= '0;
      nbit <= '0;
      data <= '0;
      bad <= 1'b0;
    end else begin
      sync <= {sync[1:0], rx};
      if (state == IDLE) begin
        cnt <= CW'(HALF - 1);
        nbit <= '0;
        bad <= 1'b0;
      end else if (!tick) cnt <= cnt - 1'b1;
      else if (state != STOP) cnt <= CW'(BIT_CYC - 1);
      if (state == DATA && tick) begin
        data <= {line, data[7:1]};
        nbit <= nbit + 1'b1;
      end
      if (frame_err) bad <= 1'b1;
    end
endmodule

// File: rtl/dac_board_3.sv
// dac_board_3: UART-fed 16-bit sample assembler driving a first-order delta-sigma DAC.
// Define RX_RESYNC_TIMEOUT_EN to drop a lone low byte after a long idle gap.
module dac_board_3
  import dac_board_3_pkg::*;
#(
  parameter int CLK_FREQ = DEF_CLK_FREQ,
  parameter int BAUD = DEF_BAUD
) (
  input  logic        CLK_IN,
  input  logic        RSTN_i,
  input  logic        UART_RX_i,
  output logic        DAC_o,
  output logic [15:0] SAMPLE_o,
  output logic        SAMPLE_VALID_o,
  output logic        RX_ERR_o
);
  localparam int RX_BIT = CLK_FREQ / BAUD;
  phase_t phase;
  logic [7:0] rx_data, low;
  logic rx_valid, rx_err, rx_busy, tmo_hit;
  logic [16:0] acc;
  logic [15:0] u;
  uart_rx_8n1 #(.BIT_CYC(RX_BIT)) u_rx (
    .clk(CLK_IN),
    .rst_n(RSTN_i),
    .rx(UART_RX_i),
    .data(rx_data),
    .data_valid(rx_valid),
    .frame_err(rx_err),
    .busy(rx_busy)
  );
`ifdef RX_RESYNC_TIMEOUT_EN
  localparam int TIMEOUT_CYCLES = 4 * 10 * RX_BIT;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo;
  assign tmo_hit = phase == HIGH && !rx_busy && tmo == TW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge CLK_IN or negedge RSTN_i)
    if (!RSTN_i) tmo <= '0;
    else tmo <= (phase == HIGH && !rx_busy && !tmo_hit) ? tmo + 1'b1 : '0;
`else
  logic unused_busy;
  assign unused_busy = rx_busy;
  assign tmo_hit = 1'b0;
`endif
  // flipping the sign bit maps two's complement onto 0..65535 for the accumulator
  assign u = {~SAMPLE_o[15], SAMPLE_o[14:0]};
  always_ff @(posedge CLK_IN or negedge RSTN_i)
    if (!RSTN_i) begin
      phase <= LOW;
      low <= '0;
      SAMPLE_o <= '0;
      SAMPLE_VALID_o <= 1'b0;
      RX_ERR_o <= 1'b0;
      acc <= '0;
      DAC_o <= 1'b0;
    end else begin
      SAMPLE_VALID_o <= rx_valid && phase == HIGH;
      RX_ERR_o <= rx_err;
      if (rx_valid && phase == HIGH) SAMPLE_o <= {rx_data, low};
      if (rx_valid) begin
        phase <= phase == LOW ? HIGH : LOW;
        if (phase == LOW) low <= rx_data;
      end else if (tmo_hit) begin
        phase <= LOW;
        low <= '0;
      end
      acc <= {1'b0, acc[15:0]} + {1'b0, u};
      DAC_o <= acc[16];
    end
endmodule

// File: tb/tb_dac_board_3.sv
// tb_dac_board_3: directed UART frames with a sample scoreboard and DAC ones-density checks
`timescale 1ns/1ps
module tb_dac_board_3;
  localparam int BIT = 52;
  localparam int TMO = 4 * 10 * BIT;
  logic clk = 1'b0, rstn = 1'b0, rx = 1'b1;
  logic dac, sv, err;
  logic [15:0] sample, mon_e;
  int n_cmp = 0, n_bad = 0, n_valid = 0, n_err = 0;
  logic [15:0] exp_q[$];

  always #41.667 clk = ~clk;

  dac_board_3 dut (
    .CLK_IN(clk),
    .RSTN_i(rstn),
    .UART_RX_i(rx),
    .DAC_o(dac),
    .SAMPLE_o(sample),
    .SAMPLE_VALID_o(sv),
    .RX_ERR_o(err)
  );

  task automatic chk(input string name, input int got, input int lo, input int hi);
    n_cmp++;
    if (got < lo || got > hi) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h), required %0d..%0d", name, got, got, lo, hi);
    end
  endtask

  always @(negedge clk)
    if (rstn) begin
      if (sv) begin
        n_valid++;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_sample: got 0x%04h, required no pulse", sample);
        end else begin
          mon_e = exp_q.pop_front();
          if (sample !== mon_e) begin
            n_bad++;
            $display("FAIL sample: got 0x%04h, required 0x%04h", sample, mon_e);
          end
        end
      end
      if (err) n_err++;
    end

  task automatic bit_(input logic v);
    rx = v;
    repeat (BIT) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b, input logic stop);
    bit_(1'b0);
    for (int i = 0; i < 8; i++) bit_(b[i]);
    bit_(stop);
  endtask

  task automatic pair(input logic [15:0] w);
    exp_q.push_back(w);
    send(w[7:0], 1'b1);
    send(w[15:8], 1'b1);
  endtask

  task automatic drain(input string name);
    repeat (3) @(negedge clk);
    chk(name, exp_q.size(), 0, 0);
    exp_q.delete();
  endtask

  task automatic density(input string name, input int n, input int lo, input int hi);
    int ones;
    ones = 0;
    repeat (4) @(negedge clk);
    repeat (n) begin
      @(negedge clk);
      ones += int'(dac);
    end
    chk(name, ones, lo, hi);
  endtask

  initial begin
    int v0, e0;
    repeat (5) @(negedge clk);
    chk("rst_sample", sample, 0, 0);
    chk("rst_valid", sv, 0, 0);
    chk("rst_err", err, 0, 0);
    chk("rst_dac", dac, 0, 0);
    rstn = 1'b1;
    density("dens_0000", 1024, 511, 513);

    v0 = n_valid;
    pair(16'h4000);
    drain("drain_4000");
    chk("pulses_4000", n_valid - v0, 1, 1);
    density("dens_4000", 4096, 3072, 3072);

    v0 = n_valid;
    pair(16'h6100);
    pair(16'h9003);
    drain("drain_b2b");
    chk("pulses_b2b", n_valid - v0, 2, 2);
    chk("sample_9003", sample, 16'h9003, 16'h9003);
    density("dens_9003", 4096, 256, 257);

    pair(16'h8000);
    drain("drain_8000");
    density("dens_8000", 4096, 0, 0);
    pair(16'h7FFF);
    drain("drain_7fff");
    density("dens_7fff", 4096, 4095, 4096);

    v0 = n_valid;
    e0 = n_err;
    send(8'h11, 1'b0);
    bit_(1'b1);
    chk("frame_err_pulses", n_err - e0, 1, 1);
    chk("frame_err_no_sample", n_valid - v0, 0, 0);
    pair(16'h0029);
    drain("drain_0029");
    chk("sample_0029", sample, 16'h0029, 16'h0029);

    rx = 1'b0;
    repeat (10) @(negedge clk);
    rx = 1'b1;
    repeat (60) @(negedge clk);
    v0 = n_valid;
    pair(16'h4009);
    drain("drain_4009");
    chk("pulses_glitch", n_valid - v0, 1, 1);

    send(8'h33, 1'b1);
    bit_(1'b0);
    bit_(1'b1);
    bit_(1'b0);
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_rst_sample", sample, 0, 0);
    chk("mid_rst_dac", dac, 0, 0);
    chk("mid_rst_valid", sv, 0, 0);
    rx = 1'b1;
    repeat (5) @(negedge clk);
    rstn = 1'b1;
    repeat (100) @(negedge clk);
    pair(16'h9119);
    drain("drain_9119");

    send(8'h55, 1'b1);
    rx = 1'b1;
    repeat (TMO + 200) @(negedge clk);
`ifdef RX_RESYNC_TIMEOUT_EN
    exp_q.push_back(16'h9119);
`else
    exp_q.push_back(16'h1955);
`endif
    send(8'h19, 1'b1);
    send(8'h91, 1'b1);
    drain("drain_timeout");
    chk("err_total", n_err, 1, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
